food_placer: RTL and testbench
==============================

// Module: food_placer
// PURPOSE
//   Consumes the free-running X/Y pseudo-random words from the coordinate LFSR and turns them into a legal food cell.
//   Reduces each raw word modulo the playfield grid size and checks the cell against snake-body occupancy.
//   Retries with fresh LFSR samples on collision; presents a stable food position to the game controller and renderer.
// PARAMETERS
//   COORD_W    10   width of raw LFSR words rand_x/rand_y
//   GRID_W     64   playfield width in cells (2..2**COORD_W-1)
//   GRID_H     48   playfield height in cells (2..2**COORD_W-1)
//   MAX_RETRY  16   collision retries before giving up (>=1)
// PORTS
//   clk1        in   1          system clock; all state on posedge
//   rst1_n      in   1          asynchronous, active-low reset
//   rand_x      in   COORD_W    raw X word from LFSR (changes every clk1)
//   rand_y      in   COORD_W    raw Y word from LFSR
//   spawn_req   in   1          1-cycle request for a new food cell
//   occ_req     out  1          occupancy query valid
//   occ_x       out  COORD_W    queried cell X (0..GRID_W-1)
//   occ_y       out  COORD_W    queried cell Y (0..GRID_H-1)
//   occ_ack     in   1          occupancy answer valid
//   occ_hit     in   1          1 = queried cell occupied by snake; sampled only with occ_ack
//   food_x      out  COORD_W    placed food X cell
//   food_y      out  COORD_W    placed food Y cell
//   food_valid  out  1          food_x/food_y hold a legal, unoccupied cell
//   busy        out  1          placement in progress
//   spawn_fail  out  1          1-cycle pulse: MAX_RETRY exhausted
// BEHAVIOUR
//   Reset: all outputs 0; FSM=IDLE; retry_cnt=0. Takes effect mid-operation in any state (query abandoned, occ_req drops).
//   FSM states:
//   - IDLE: spawn_req=1 -> SAMPLE. Clears food_valid on the next edge; sets busy.
//   - SAMPLE: registers rx<=rand_x, ry<=rand_y -> REDUCE.
//   - REDUCE: each cycle rx-=GRID_W if rx>=GRID_W, and ry-=GRID_H if ry>=GRID_H, in parallel.
//     Both in range -> QUERY. Worst case ceil(2**COORD_W/min(GRID_W,GRID_H)) cycles.
//   - QUERY: registers occ_req=1, occ_x=rx, occ_y=ry -> WAIT_ACK.
//   - WAIT_ACK: occ_req/occ_x/occ_y held stable until occ_ack=1. occ_ack is never seen in the cycle occ_req first rises.
//     - ack & !hit: food_x/food_y<=rx/ry, food_valid<=1, busy<=0, occ_req<=0, retry_cnt<=0 -> IDLE.
//     - ack & hit & retry_cnt<MAX_RETRY-1: retry_cnt++, occ_req<=0 -> SAMPLE (fresh LFSR word).
//     - ack & hit & last retry: spawn_fail<=1 for one cycle, food_valid stays 0, busy<=0, retry_cnt<=0 -> IDLE.
//   spawn_req while busy: ignored, not queued. occ_ack/occ_hit outside WAIT_ACK: ignored.
//   food_valid, food_x and food_y hold until the next accepted spawn_req or reset.
//   Arithmetic: unsigned COORD_W-bit subtract; no wrap possible since it is guarded by the compare.
//   Min latency spawn_req->food_valid: 4 cycles + ack delay (already in range, no hit).
// STRUCTURE
//   snake_pkg: GRID_W/GRID_H/COORD_W constants shared with LFSR, body tracker and renderer; food FSM state encoding.
//   Sub-module mod_reduce (iterative compare-subtract, load/done handshake), instantiated for X and Y.
//   FSM, retry counter and output registers stay in food_placer.
// TESTING
//   - Reset: hold rst1_n=0 -> all outputs 0. Release, idle 10 cycles -> outputs unchanged.
//   - GRID 64x48, rand=(100,70), ack no-hit 1 cycle after occ_req -> occ query (36,22); food=(36,22), valid after 2 reduce cycles.
//   - rand=(1023,1023) -> food=(63,15) after 21 REDUCE cycles. Check occ_x/occ_y stable while ack delayed 5 cycles.
//   - First query hit, second no-hit -> exactly two occ_req transactions; food = second cell; spawn_fail never pulses.
//   - occ_hit=1 on every ack -> 16 queries, then one spawn_fail pulse; food_valid=0, busy=0.
//   - spawn_req during WAIT_ACK -> ignored, one placement only.
//   - rst1_n pulse in WAIT_ACK -> occ_req=0 immediately; a new spawn_req then completes normally.

Source files
------------

// File: rtl/snake_pkg.sv
// Playfield geometry shared by the LFSR, body tracker, renderer and food placer,
// plus the food placer state encoding.
package snake_pkg;

    localparam int SNAKE_COORD_W  = 10;
    localparam int SNAKE_GRID_W   = 64;
    localparam int SNAKE_GRID_H   = 48;
    localparam int FOOD_MAX_RETRY = 16;

    typedef enum logic [2:0] {
        FS_IDLE     = 3'd0,
        FS_SAMPLE   = 3'd1,
        FS_REDUCE   = 3'd2,
        FS_QUERY    = 3'd3,
        FS_WAIT_ACK = 3'd4
    } food_state_e;

endpackage

// File: rtl/mod_reduce.sv
// Iterative modulo by repeated compare-subtract. load captures a raw word; the
// value then steps down by MOD each cycle until it is below MOD (done).
module mod_reduce #(
    parameter int W   = 10,
    parameter int MOD = 64
) (
    input  logic         clk1,
    input  logic         rst1_n,
    input  logic         load,
    input  logic [W-1:0] din,
    output logic [W-1:0] val,
    output logic         done
);

    localparam logic [W-1:0] MOD_W = W'(MOD);

    logic [W-1:0] val_q, val_d;

    always_comb begin
        val_d = val_q;
        if (load) begin
            val_d = din;
        end else if (val_q >= MOD_W) begin
            val_d = val_q - MOD_W;
        end
    end

    always_ff @(posedge clk1 or negedge rst1_n) begin
        if (!rst1_n) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

    assign val  = val_q;
    assign done = (val_q < MOD_W);

endmodule

// File: rtl/food_placer.sv
// Turns raw LFSR X/Y words into a legal, unoccupied food cell, retrying with
// fresh samples on snake-body collisions.
//
// state       | meaning
// ------------+-----------------------------------------------
// FS_IDLE     | waiting for spawn_req; food outputs held
// FS_SAMPLE   | load raw rand_x/rand_y into the reducers
// FS_REDUCE   | compare-subtract until both coords are in range
// FS_QUERY    | launch occupancy query for the reduced cell
// FS_WAIT_ACK | hold query until occ_ack, then place/retry/fail
module food_placer
    import snake_pkg::*;
#(
    parameter int COORD_W   = SNAKE_COORD_W,
    parameter int GRID_W    = SNAKE_GRID_W,
    parameter int GRID_H    = SNAKE_GRID_H,
    parameter int MAX_RETRY = FOOD_MAX_RETRY
) (
    input  logic               clk1,
    input  logic               rst1_n,
    input  logic [COORD_W-1:0] rand_x,
    input  logic [COORD_W-1:0] rand_y,
    input  logic               spawn_req,
    output logic               occ_req,
    output logic [COORD_W-1:0] occ_x,
    output logic [COORD_W-1:0] occ_y,
    input  logic               occ_ack,
    input  logic               occ_hit,
    output logic [COORD_W-1:0] food_x,
    output logic [COORD_W-1:0] food_y,
    output logic               food_valid,
    output logic               busy,
    output logic               spawn_fail
);

    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] LAST_RETRY = RW'(MAX_RETRY - 1);

    food_state_e        state_q, state_d;
    logic [RW-1:0]      retry_q, retry_d;
    logic               occ_req_q, occ_req_d;
    logic [COORD_W-1:0] occ_x_q, occ_x_d, occ_y_q, occ_y_d;
    logic [COORD_W-1:0] food_x_q, food_x_d, food_y_q, food_y_d;
    logic               food_valid_q, food_valid_d;
    logic               busy_q, busy_d;
    logic               spawn_fail_q, spawn_fail_d;

    logic               load;
    logic [COORD_W-1:0] rx, ry;
    logic               x_done, y_done;

    assign load = (state_q == FS_SAMPLE);

    mod_reduce #(.W(COORD_W), .MOD(GRID_W)) u_reduce_x (
        .clk1   (clk1),
        .rst1_n (rst1_n),
        .load   (load),
        .din    (rand_x),
        .val    (rx),
        .done   (x_done)
    );

    mod_reduce #(.W(COORD_W), .MOD(GRID_H)) u_reduce_y (
        .clk1   (clk1),
        .rst1_n (rst1_n),
        .load   (load),
        .din    (rand_y),
        .val    (ry),
        .done   (y_done)
    );

    always_comb begin
        state_d      = state_q;
        retry_d      = retry_q;
        occ_req_d    = occ_req_q;
        occ_x_d      = occ_x_q;
        occ_y_d      = occ_y_q;
        food_x_d     = food_x_q;
        food_y_d     = food_y_q;
        food_valid_d = food_valid_q;
        busy_d       = busy_q;
        spawn_fail_d = 1'b0;

        case (state_q)
            FS_IDLE: begin
                if (spawn_req) begin
                    food_valid_d = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = FS_SAMPLE;
                end
            end
            FS_SAMPLE: begin
                state_d = FS_REDUCE;
            end
            FS_REDUCE: begin
                if (x_done && y_done) begin
                    state_d = FS_QUERY;
                end
            end
            FS_QUERY: begin
                occ_req_d = 1'b1;
                occ_x_d   = rx;
                occ_y_d   = ry;
                state_d   = FS_WAIT_ACK;
            end
            FS_WAIT_ACK: begin
                if (occ_ack) begin
                    occ_req_d = 1'b0;
                    if (!occ_hit) begin
                        food_x_d     = rx;
                        food_y_d     = ry;
                        food_valid_d = 1'b1;
                        busy_d       = 1'b0;
                        retry_d      = '0;
                        state_d      = FS_IDLE;
                    end else if (retry_q < LAST_RETRY) begin
                        retry_d = retry_q + RW'(1);
                        state_d = FS_SAMPLE;
                    end else begin
                        spawn_fail_d = 1'b1;
                        busy_d       = 1'b0;
                        retry_d      = '0;
                        state_d      = FS_IDLE;
                    end
                end
            end
            default: begin
                state_d = FS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk1 or negedge rst1_n) begin
        if (!rst1_n) begin
            state_q      <= FS_IDLE;
            retry_q      <= '0;
            occ_req_q    <= 1'b0;
            occ_x_q      <= '0;
            occ_y_q      <= '0;
            food_x_q     <= '0;
            food_y_q     <= '0;
            food_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            spawn_fail_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            retry_q      <= retry_d;
            occ_req_q    <= occ_req_d;
            occ_x_q      <= occ_x_d;
            occ_y_q      <= occ_y_d;
            food_x_q     <= food_x_d;
            food_y_q     <= food_y_d;
            food_valid_q <= food_valid_d;
            busy_q       <= busy_d;
            spawn_fail_q <= spawn_fail_d;
        end
    end

    assign occ_req    = occ_req_q;
    assign occ_x      = occ_x_q;
    assign occ_y      = occ_y_q;
    assign food_x     = food_x_q;
    assign food_y     = food_y_q;
    assign food_valid = food_valid_q;
    assign busy       = busy_q;
    assign spawn_fail = spawn_fail_q;

endmodule

// File: tb/tb_food_placer.sv
// Directed bench for food_placer on a 64x48 grid with a scripted occupancy
// responder that answers each query after a programmable delay.
module tb_food_placer;

    logic       clk1 = 1'b0;
    logic       rst1_n = 1'b0;
    logic [9:0] rand_x = '0, rand_y = '0;
    logic       spawn_req = 1'b0;
    logic       occ_req;
    logic [9:0] occ_x, occ_y;
    logic       occ_ack = 1'b0, occ_hit = 1'b0;
    logic [9:0] food_x, food_y;
    logic       food_valid, busy, spawn_fail;

    int n_checks = 0;
    int n_fail   = 0;

    int         ack_delay = 1;
    int         hits_left = 0;
    int         pend = -1;
    int         n_query = 0;
    int         n_failp = 0;
    logic [9:0] cap_x, cap_y, first_qx, first_qy;
    logic [9:0] next_rx, next_ry;

    food_placer dut (
        .clk1       (clk1),
        .rst1_n     (rst1_n),
        .rand_x     (rand_x),
        .rand_y     (rand_y),
        .spawn_req  (spawn_req),
        .occ_req    (occ_req),
        .occ_x      (occ_x),
        .occ_y      (occ_y),
        .occ_ack    (occ_ack),
        .occ_hit    (occ_hit),
        .food_x     (food_x),
        .food_y     (food_y),
        .food_valid (food_valid),
        .busy       (busy),
        .spawn_fail (spawn_fail)
    );

    always #5 clk1 = ~clk1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Occupancy responder: ack_delay=1 means ack lands one full cycle after occ_req rises.
    always @(negedge clk1) begin
        occ_ack = 1'b0;
        occ_hit = 1'b0;
        if (spawn_fail) n_failp++;
        if (!rst1_n) begin
            pend = -1;
        end else if (pend > 0) begin
            chk("occ_req_held", occ_req, 1);
            chk("occ_x_held", occ_x, cap_x);
            chk("occ_y_held", occ_y, cap_y);
            pend--;
            if (pend == 0) begin
                occ_ack = 1'b1;
                pend = -1;
                if (hits_left > 0) begin
                    occ_hit = 1'b1;
                    hits_left--;
                    rand_x = next_rx;
                    rand_y = next_ry;
                end
            end
        end else if (occ_req && pend < 0) begin
            n_query++;
            cap_x = occ_x;
            cap_y = occ_y;
            if (n_query == 1) begin
                first_qx = occ_x;
                first_qy = occ_y;
            end
            pend = ack_delay;
        end
    end

    task automatic start(input logic [9:0] rx, input logic [9:0] ry, input int dly, input int hits);
        rand_x = rx;
        rand_y = ry;
        next_rx = rx;
        next_ry = ry;
        ack_delay = dly;
        hits_left = hits;
        n_query = 0;
        n_failp = 0;
        @(negedge clk1);
        spawn_req = 1'b1;
        @(negedge clk1);
        spawn_req = 1'b0;
        chk("busy_set", busy, 1);
        chk("valid_cleared", food_valid, 0);
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy && cyc < 3000) begin
            @(negedge clk1);
            cyc++;
        end
        if (busy) chk("timeout_busy", 1, 0);
    endtask

    task automatic expect_end(input string tag, input int queries, input int fails,
                              input logic valid, input logic [9:0] fx, input logic [9:0] fy);
        chk({tag, "_queries"}, n_query, queries);
        chk({tag, "_fail_pulses"}, n_failp, fails);
        chk({tag, "_valid"}, food_valid, valid);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_occ_req"}, occ_req, 0);
        if (valid) begin
            chk({tag, "_food_x"}, food_x, fx);
            chk({tag, "_food_y"}, food_y, fy);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_occ_req"}, occ_req, 0);
        chk({tag, "_occ_xy"}, {occ_x, occ_y}, 0);
        chk({tag, "_food_xy"}, {food_x, food_y}, 0);
        chk({tag, "_valid"}, food_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_fail"}, spawn_fail, 0);
    endtask

    initial begin
        int cyc;

        repeat (3) @(negedge clk1);
        check_all_zero("reset");
        rst1_n = 1'b1;
        repeat (10) @(negedge clk1);
        check_all_zero("post_reset_idle");

        // In range already: spawn edge, SAMPLE, REDUCE, QUERY, ack seen 2 edges later.
        start(10'd10, 10'd20, 1, 0);
        wait_idle(cyc);
        chk("lat_in_range", cyc, 5);
        expect_end("in_range", 1, 0, 1, 10'd10, 10'd20);

        // One subtract each, one extra REDUCE cycle versus the in-range case.
        start(10'd100, 10'd70, 1, 0);
        wait_idle(cyc);
        chk("lat_100_70", cyc, 6);
        chk("q_100_70_x", first_qx, 36);
        chk("q_100_70_y", first_qy, 22);
        expect_end("r100_70", 1, 0, 1, 10'd36, 10'd22);

        // Worst case: 1023 mod 64 = 63, 1023 mod 48 = 15; ack delayed 5 cycles.
        start(10'd1023, 10'd1023, 5, 0);
        wait_idle(cyc);
        chk("q_1023_x", first_qx, 63);
        chk("q_1023_y", first_qy, 15);
        expect_end("r1023", 1, 0, 1, 10'd63, 10'd15);

        // Every answer is a hit: 16 queries then a single fail pulse.
        start(10'd3, 10'd4, 1, 1000);
        wait_idle(cyc);
        repeat (3) @(negedge clk1);
        expect_end("all_hit", 16, 1, 0, 10'd0, 10'd0);
        hits_left = 0;

        // First query hits, resample yields (5,7) which is free.
        start(10'd100, 10'd70, 2, 1);
        next_rx = 10'd5;
        next_ry = 10'd7;
        wait_idle(cyc);
        chk("hit1_first_x", first_qx, 36);
        chk("hit1_first_y", first_qy, 22);
        expect_end("hit_once", 2, 0, 1, 10'd5, 10'd7);

        // spawn_req while waiting for ack is dropped, not queued.
        start(10'd130, 10'd50, 8, 0);
        cyc = 0;
        while (!occ_req && cyc < 100) begin
            @(negedge clk1);
            cyc++;
        end
        chk("busy_req_seen", occ_req, 1);
        rand_x = 10'd7;
        rand_y = 10'd8;
        spawn_req = 1'b1;
        @(negedge clk1);
        spawn_req = 1'b0;
        wait_idle(cyc);
        cyc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk1);
            if (busy) cyc++;
        end
        chk("ignored_busy_cycles", cyc, 0);
        expect_end("ignored", 1, 0, 1, 10'd2, 10'd2);

        // Asynchronous reset while the query is outstanding.
        start(10'd40, 10'd30, 30, 0);
        cyc = 0;
        while (!occ_req && cyc < 100) begin
            @(negedge clk1);
            cyc++;
        end
        chk("rst_req_seen", occ_req, 1);
        @(negedge clk1);
        #2 rst1_n = 1'b0;
        #1;
        chk("rst_occ_req", occ_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", food_valid, 0);
        @(negedge clk1);
        @(negedge clk1);
        #2 rst1_n = 1'b1;
        start(10'd77, 10'd49, 1, 0);
        wait_idle(cyc);
        expect_end("after_rst", 1, 0, 1, 10'd13, 10'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
